// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//
// Contents:
//   state_t         loader FSM states (IDLE, LEN0, LEN1, DATA, CSUM)
//   BYTES_PER_WORD  stream bytes per instruction word
//   LEN_W           width of the word-count field in the stream header
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian word assembler for the program loader.
//
// Bytes arrive least-significant first and are shifted in from the top,
// so after four shifts the register holds {b3,b2,b1,b0}.
//
// Ports:
//   clk         input   rising-edge clock
//   reset       input   asynchronous active-low reset
//   clear       input   restart assembly at byte 0 (new load)
//   shift_en    input   accept byte_in this cycle
//   byte_in     input   8-bit stream byte
//   last_byte   output  next accepted byte completes a word (combinational)
//   word_ready  output  one-cycle strobe, the cycle after a word completes
//   word        output  assembled 32-bit word
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_idx;
    logic [31:0] shreg;

    // The byte index wraps naturally after the fourth byte, so consecutive
    // words need no explicit restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx   <= 2'd0;
            shreg      <= 32'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= shift_en && (byte_idx == LAST_IDX);
            if (clear) begin
                byte_idx <= 2'd0;
                shreg    <= 32'd0;
            end else if (shift_en) begin
                shreg    <= {byte_in, shreg[31:8]};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    assign last_byte = (byte_idx == LAST_IDX);
    assign word      = shreg;

endmodule

// File: rtl/imem_loader.sv
// Program loader: write side of the instruction memory.
//
// Accepts a length-prefixed, XOR-checksummed byte stream
// (LEN_LO, LEN_HI, 4*N data bytes, CSUM) and writes little-endian words
// sequentially from address 0, holding the core in reset while loading.
//
// Ports:
//   clk         input   rising-edge clock
//   reset       input   asynchronous active-low reset
//   start       input   one-cycle load request, honoured only in IDLE
//   rx_valid    input   stream byte available
//   rx_data     input   stream byte
//   rx_ready    output  loader accepts a byte (any non-IDLE state)
//   imem_we     output  instruction memory write strobe, one cycle per word
//   imem_addr   output  word-aligned byte address of the write
//   imem_wdata  output  assembled instruction word
//   core_hold   output  keeps core and PC in reset while high
//   busy        output  high in every state except IDLE
//   done        output  one-cycle pulse on a successful load
//   err         output  sticky error, cleared by the next accepted start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [IDX_W-1:0]  len_ext;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  word_idx_next;
    logic [7:0]        csum;
    logic              xfer;
    logic              start_load;
    logic              last_byte;

    assign xfer          = rx_valid && rx_ready;
    assign start_load    = (state == IDLE) && start;
    assign len_full      = {rx_data, len[7:0]};
    assign len_ext       = IDX_W'(len);
    assign word_idx_next = word_idx + IDX_ONE;

    // Ready, busy and hold all follow the state register directly, so an
    // asynchronous reset drops them at once.
    assign rx_ready  = (state != IDLE);
    assign busy      = (state != IDLE);
    assign core_hold = (state != IDLE);

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .shift_en   (xfer && (state == DATA)),
        .byte_in    (rx_data),
        .last_byte  (last_byte),
        .word_ready (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length image skips DATA entirely; its expected checksum is
    // the untouched running XOR, i.e. 0x00.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LEN0;
            LEN0: if (xfer) state_next = LEN1;
            LEN1: begin
                if (xfer) begin
                    if (len_full > DEPTH_LEN) begin
                        state_next = IDLE;
                    end else if (len_full == '0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && last_byte && (word_idx_next == len_ext)) begin
                    state_next = CSUM;
                end
            end
            CSUM: if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The write address is captured on the fourth byte of a word so it is
    // valid alongside the assembler's write strobe one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            word_idx  <= '0;
            csum      <= 8'd0;
            imem_addr <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        word_idx <= '0;
                        csum     <= 8'd0;
                    end
                end
                LEN0: if (xfer) len[7:0] <= rx_data;
                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        if (len_full > DEPTH_LEN) err <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ rx_data;
                        if (last_byte) begin
                            imem_addr <= {word_idx, 2'b00};
                            word_idx  <= word_idx_next;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (rx_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
